// File: rtl/scr1_dmem_wb_bridge_pkg.sv
// Shared data-memory interface codes for the core and the Wishbone bridge.
// Response, command and width encodings plus the bridge FSM states.
package scr1_dmem_wb_bridge_pkg;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;
    localparam logic [1:0] WIDTH_BAD  = 2'b11;

    typedef enum logic [1:0] {
        RESP_IDLE  = 2'b00,
        RESP_OKAY  = 2'b01,
        RESP_ERROR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } state_t;

endpackage

// File: rtl/scr1_dmem_wb_lane.sv
// Byte-lane mapping: width and low address bits to selects,
// replicated write data and an illegal/misaligned flag.
module scr1_dmem_wb_lane
    import scr1_dmem_wb_bridge_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  sel,
    output logic [31:0] dat,
    output logic        misalign
);

    always_comb begin
        sel      = 4'b0000;
        dat      = wdata;
        misalign = 1'b0;
        case (width)
            WIDTH_BYTE: begin
                sel = 4'b0001 << addr_lo;
                dat = {4{wdata[7:0]}};
            end
            WIDTH_HALF: begin
                sel      = addr_lo[1] ? 4'b1100 : 4'b0011;
                dat      = {2{wdata[15:0]}};
                misalign = addr_lo[0];
            end
            WIDTH_WORD: begin
                sel      = 4'b1111;
                misalign = |addr_lo;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/scr1_dmem_wb_bridge.sv
// Core data-memory port to single-master Wishbone classic bridge.
// One access in flight; every accepted request gets exactly one response.
module scr1_dmem_wb_bridge
    import scr1_dmem_wb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req_i,
    input  logic        dmem_cmd_i,
    input  logic [1:0]  dmem_width_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_req_ack_o,
    output logic [31:0] dmem_rdata_o,
    output logic [1:0]  dmem_resp_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [29:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    state_t        state;
    resp_t         resp_q;
    logic          cyc_q;
    logic [CW-1:0] cnt;
    logic          timed_out;

    logic [3:0]    lane_sel;
    logic [31:0]   lane_dat;
    logic          lane_bad;

    scr1_dmem_wb_lane u_lane (
        .width    (dmem_width_i),
        .addr_lo  (dmem_addr_i[1:0]),
        .wdata    (dmem_wdata_i),
        .sel      (lane_sel),
        .dat      (lane_dat),
        .misalign (lane_bad)
    );

    assign dmem_req_ack_o = dmem_req_i && (state == ST_IDLE);
    assign dmem_resp_o    = resp_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_stb_o       = cyc_q;

    // Fires on the last permitted BUS cycle, so stb stays high TMO cycles.
    assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt + CW'(1) == TMO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            resp_q       <= RESP_IDLE;
            cyc_q        <= 1'b0;
            cnt          <= '0;
            wb_we_o      <= 1'b0;
            wb_adr_o     <= '0;
            wb_sel_o     <= '0;
            wb_dat_o     <= '0;
            dmem_rdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dmem_req_i) begin
                        if (lane_bad) begin
                            state  <= ST_RESP;
                            resp_q <= RESP_ERROR;
                        end else begin
                            state    <= ST_BUS;
                            cyc_q    <= 1'b1;
                            cnt      <= '0;
                            wb_we_o  <= (dmem_cmd_i == CMD_WR);
                            wb_adr_o <= dmem_addr_i[31:2];
                            wb_sel_o <= lane_sel;
                            wb_dat_o <= lane_dat;
                        end
                    end
                end
                ST_BUS: begin
                    if (wb_err_i) begin
                        state  <= ST_RESP;
                        cyc_q  <= 1'b0;
                        resp_q <= RESP_ERROR;
                    end else if (wb_ack_i) begin
                        state  <= ST_RESP;
                        cyc_q  <= 1'b0;
                        resp_q <= RESP_OKAY;
                        if (!wb_we_o) begin
                            dmem_rdata_o <= wb_dat_i;
                        end
                    end else if (timed_out) begin
                        state  <= ST_RESP;
                        cyc_q  <= 1'b0;
                        resp_q <= RESP_ERROR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    state        <= ST_IDLE;
                    resp_q       <= RESP_IDLE;
                    dmem_rdata_o <= '0;
                end
                default: begin
                    state  <= ST_IDLE;
                    resp_q <= RESP_IDLE;
                    cyc_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scr1_dmem_wb_bridge.sv
// Scoreboard bench: driver queues expected responses and bus plans,
// a slave model answers the bus, a monitor checks core responses.
module tb_scr1_dmem_wb_bridge;

    localparam int TO = 4;
    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_BOTH = 2;
    localparam int K_SILENT = 3;
    localparam int K_ABORT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmem_req_i = 1'b0;
    logic        dmem_cmd_i = 1'b0;
    logic [1:0]  dmem_width_i = 2'b00;
    logic [31:0] dmem_addr_i = '0;
    logic [31:0] dmem_wdata_i = '0;
    logic        dmem_req_ack_o;
    logic [31:0] dmem_rdata_o;
    logic [1:0]  dmem_resp_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [29:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;

    scr1_dmem_wb_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .dmem_req_i     (dmem_req_i),
        .dmem_cmd_i     (dmem_cmd_i),
        .dmem_width_i   (dmem_width_i),
        .dmem_addr_i    (dmem_addr_i),
        .dmem_wdata_i   (dmem_wdata_i),
        .dmem_req_ack_o (dmem_req_ack_o),
        .dmem_rdata_o   (dmem_rdata_o),
        .dmem_resp_o    (dmem_resp_o),
        .wb_cyc_o       (wb_cyc_o),
        .wb_stb_o       (wb_stb_o),
        .wb_we_o        (wb_we_o),
        .wb_adr_o       (wb_adr_o),
        .wb_sel_o       (wb_sel_o),
        .wb_dat_o       (wb_dat_o),
        .wb_dat_i       (wb_dat_i),
        .wb_ack_i       (wb_ack_i),
        .wb_err_i       (wb_err_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;

    typedef struct {
        logic [29:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
        int          kind;
        int          dly;
        logic [31:0] rd;
        int          stb_n;
    } plan_t;

    exp_t  rq[$];
    plan_t pq[$];

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int resp_seen = 0;
    int prev_acc = 0;
    int prev_lat = 0;
    bit prev_ok = 0;

    always @(posedge clk) cyc_n++;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, got, exp, cyc_n);
        end
    endtask

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && dmem_resp_o != 2'b00) begin
            exp_t e;
            resp_seen++;
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got %0h expected none",
                         dmem_resp_o);
            end else begin
                e = rq.pop_front();
                check("resp", 32'(dmem_resp_o), 32'(e.resp));
                check("rdata", dmem_rdata_o, e.rdata);
                check("resp_latency", 32'(cyc_n - e.acc), 32'(e.lat));
            end
        end
    end

    // Wishbone slave model driven by per-access plans.
    plan_t cur;
    int    bcnt = 0;
    always @(negedge clk) begin
        check("cyc_eq_stb", 32'(wb_cyc_o), 32'(wb_stb_o));
        if (wb_stb_o) begin
            if (bcnt == 0) begin
                if (pq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cyc: got 1 expected 0");
                    cur = '{default: 0, kind: K_SILENT, stb_n: -1};
                end else begin
                    cur = pq.pop_front();
                    check("wb_adr", 32'(wb_adr_o), 32'(cur.adr));
                    check("wb_sel", 32'(wb_sel_o), 32'(cur.sel));
                    check("wb_dat", wb_dat_o, cur.dat);
                    check("wb_we", 32'(wb_we_o), 32'(cur.we));
                end
            end
            if (cur.kind < K_SILENT && bcnt == cur.dly) begin
                wb_ack_i = (cur.kind == K_ACK) || (cur.kind == K_BOTH);
                wb_err_i = (cur.kind == K_ERR) || (cur.kind == K_BOTH);
                wb_dat_i = cur.rd;
            end else begin
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
                wb_dat_i = $urandom;
            end
            bcnt++;
        end else begin
            if (bcnt > 0 && cur.stb_n >= 0)
                check("stb_cycles", 32'(bcnt), 32'(cur.stb_n));
            bcnt = 0;
            wb_ack_i = ($urandom % 6) == 0;
            wb_err_i = ($urandom % 6) == 0;
            wb_dat_i = $urandom;
        end
    end

    task automatic idle(input int n);
        dmem_req_i = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic cmd, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int kind, input int dly,
                         input logic [31:0] rd, input bit b2b);
        exp_t  e;
        plan_t p;
        int    waited;
        bit    bad;
        int    nb;
        dmem_req_i   = 1'b1;
        dmem_cmd_i   = cmd;
        dmem_width_i = w;
        dmem_addr_i  = a;
        dmem_wdata_i = wd;
        #1;
        waited = 0;
        while (!dmem_req_ack_o && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!dmem_req_ack_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got 0 expected 1");
            dmem_req_i = 1'b0;
            prev_ok = 0;
            return;
        end
        bad = (w == 2'd3) || (w == 2'd1 && a[0]) ||
              (w == 2'd2 && a[1:0] != 2'b00);
        e.acc = cyc_n;
        if (bad) begin
            e.resp  = 2'b10;
            e.rdata = '0;
            e.lat   = 1;
        end else begin
            nb      = 1 << w;
            p.adr   = a / 4;
            p.sel   = 4'(((1 << nb) - 1) << a[1:0]);
            p.dat   = (w == 2'd0) ? wd[7:0] * 32'h01010101 :
                      (w == 2'd1) ? wd[15:0] * 32'h00010001 : wd;
            p.we    = cmd;
            p.kind  = kind;
            p.dly   = dly;
            p.rd    = rd;
            p.stb_n = (kind >= K_SILENT) ? TO : dly + 1;
            if (kind == K_ABORT) p.stb_n = -1;
            pq.push_back(p);
            e.resp  = (kind == K_ACK) ? 2'b01 : 2'b10;
            e.rdata = (kind == K_ACK && !cmd) ? rd : 32'h0;
            e.lat   = (kind >= K_SILENT) ? TO + 1 : dly + 2;
        end
        if (b2b && prev_ok)
            check("accept_spacing", 32'(e.acc - prev_acc),
                  32'(prev_lat + 1));
        prev_acc = e.acc;
        prev_lat = e.lat;
        prev_ok  = (kind != K_ABORT) || bad;
        if (kind != K_ABORT || bad) rq.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        int seen;
        repeat (2) @(negedge clk);
        check("rst_cyc", 32'(wb_cyc_o), 0);
        check("rst_stb", 32'(wb_stb_o), 0);
        check("rst_we", 32'(wb_we_o), 0);
        check("rst_req_ack", 32'(dmem_req_ack_o), 0);
        check("rst_adr", 32'(wb_adr_o), 0);
        check("rst_sel", 32'(wb_sel_o), 0);
        check("rst_dat", wb_dat_o, 0);
        check("rst_rdata", dmem_rdata_o, 0);
        check("rst_resp", 32'(dmem_resp_o), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b0, 2'd2, 32'h1000, 0, K_ACK, 1, 32'hDEADBEEF, 0);
        idle(3);
        issue(1'b1, 2'd0, 32'h2003, 32'hA5, K_ACK, 0, 0, 0);
        idle(3);
        issue(1'b0, 2'd1, 32'h1001, 0, K_ACK, 0, 0, 0);
        idle(2);
        issue(1'b0, 2'd3, 32'h1000, 0, K_ACK, 0, 0, 0);
        idle(2);
        issue(1'b0, 2'd2, 32'h3000, 0, K_ERR, 1, 32'h1234, 0);
        idle(3);
        issue(1'b0, 2'd1, 32'h3002, 0, K_BOTH, 0, 32'h5678, 0);
        idle(3);
        issue(1'b0, 2'd2, 32'h4000, 0, K_SILENT, 0, 0, 0);
        idle(7);
        issue(1'b0, 2'd2, 32'h5000, 0, K_ACK, 0, 32'h11, 0);
        issue(1'b1, 2'd1, 32'h5006, 32'hBEEF, K_ACK, 0, 0, 1);
        issue(1'b0, 2'd0, 32'h5001, 0, K_ACK, 0, 32'h22, 1);
        idle(4);

        issue(1'b0, 2'd2, 32'h6000, 0, K_ABORT, 0, 0, 0);
        dmem_req_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_cyc", 32'(wb_cyc_o), 0);
        check("abort_stb", 32'(wb_stb_o), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = resp_seen;
        repeat (8) @(negedge clk);
        check("abort_no_resp", 32'(resp_seen), 32'(seen));
        prev_ok = 0;

        for (int i = 0; i < 200; i++) begin
            bit          b;
            logic [1:0]  w;
            logic [31:0] a;
            int          k;
            int          r;
            b = ($urandom % 2) == 1;
            if (!b) idle($urandom_range(1, 2));
            w = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom % 4 != 0 && w != 2'd3)
                a = a & ~((32'd1 << w) - 32'd1);
            r = $urandom % 10;
            k = (r < 6) ? K_ACK : (r < 7) ? K_ERR :
                (r < 8) ? K_BOTH : K_SILENT;
            issue(1'($urandom % 2), w, a, $urandom, k,
                  $urandom_range(0, 2), $urandom, b);
        end
        idle(20);
        check("resp_queue_empty", 32'(rq.size()), 0);
        check("plan_queue_empty", 32'(pq.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/scr1_dmem_wb_bridge.md
# scr1_dmem_wb_bridge

Converts the core data-memory request/response interface (req/req_ack, cmd, width, addr, wdata, 2-bit resp) into a single-master Wishbone classic cycle. Sits directly downstream of the core top's `core2dmem_*` / `dmem2core_*` ports and upstream of the SoC Wishbone interconnect. Handles one access at a time. Generates byte selects, misalignment errors and bus timeouts, so the core always receives exactly one response per accepted request.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of BUS-state cycles without ack/err before the access is aborted with ERROR; 0 disables the timeout.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `dmem_req_i`  in  1  core request valid; held until acknowledged.
- `dmem_cmd_i`  in  1  0 = read, 1 = write.
- `dmem_width_i`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `dmem_addr_i`  in  32  byte address.
- `dmem_wdata_i`  in  32  write data, LSB-justified.
- `dmem_req_ack_o`  out  1  request accepted this cycle.
- `dmem_rdata_o`  out  32  read data; valid only with OKAY on a read.
- `dmem_resp_o`  out  2  00 IDLE, 01 OKAY, 10 ERROR; one-cycle pulse.
- `wb_cyc_o`, `wb_stb_o`  out  1  Wishbone cycle/strobe; always equal.
- `wb_we_o`  out  1  write enable.
- `wb_adr_o`  out  30  word address (`addr[31:2]`).
- `wb_sel_o`  out  4  byte-lane selects.
- `wb_dat_o`  out  32  write data, lane-replicated.
- `wb_dat_i`  in  32  read data.
- `wb_ack_i`, `wb_err_i`  in  1  cycle termination.

## Operation
- FSM states: IDLE, BUS, RESP. Reset state is IDLE.
- **IDLE**
  - `dmem_req_ack_o = dmem_req_i` (combinational).
  - On acceptance, register cmd, addr, width and wdata.
  - Legality check:
    - Illegal width (11) or misalignment (halfword with `addr[0]`=1, word with `addr[1:0]`≠0) → RESP with ERROR. No bus cycle is issued.
    - Otherwise → BUS.
- **BUS**
  - Assert `cyc/stb`. `we`, `adr`, `sel` and `dat_o` come from the registered request.
  - Timeout counter clears on entry and increments each BUS cycle.
  - Exit conditions, all → RESP:
    - `wb_ack_i` alone: result OKAY; latch `wb_dat_i`.
    - `wb_err_i`, including when asserted together with ack: result ERROR.
    - Counter reaches `TIMEOUT_CYCLES` (when nonzero): result ERROR.
  - Leaving BUS deasserts `cyc/stb` at the next edge.
- **RESP**
  - Drive `dmem_resp_o` for exactly one cycle, then return to IDLE.
  - `dmem_rdata_o` holds the latched word on a read OKAY and zero otherwise.
- **Lane rules**
  - Byte: `sel = 1 << addr[1:0]`; `dat_o` = `wdata[7:0]` replicated ×4.
  - Halfword: `sel = 0011` or `1100` by `addr[1]`; `dat_o` = `wdata[15:0]` replicated ×2.
  - Word: `sel = 1111`; `dat_o = wdata`.
- Read data is returned as the raw 32-bit word, unshifted; the LSU extracts the lane.
- `dmem_req_ack_o` is 0 in BUS and RESP. A request arriving then is held by the core and accepted in the next IDLE cycle.
- ack/err arriving outside BUS is ignored.

## Timing
- Reset values:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `dmem_req_ack_o` = 0.
  - `wb_adr_o`, `wb_sel_o`, `wb_dat_o`, `dmem_rdata_o` = 0.
  - `dmem_resp_o` = 00.
- Assertion of `rst` mid-access drops `cyc/stb` immediately (asynchronously). No response is produced for the aborted access.
- Latency, with acceptance at cycle 0:
  - `stb` high from cycle 1.
  - Earliest ack at cycle 1 gives resp at cycle 2.
  - Error without a bus cycle gives resp at cycle 1.
- Minimum spacing between acceptances is 3 cycles: accept, BUS, RESP, then the next accept in IDLE.
- Timeout: with `TIMEOUT_CYCLES` = N, `stb` is high for N cycles, and ERROR is driven on cycle N+1 after acceptance.
- All outputs except `dmem_req_ack_o` are registered.

## Structure
- Response codes (IDLE/OKAY/ERROR), cmd codes and width codes belong in the shared memory-interface package; the core and this bridge use the same definitions.
- One combinational sub-module, `scr1_dmem_wb_lane`: maps width and `addr[1:0]` to `sel`, replicated write data and the misalignment flag.
- The FSM and timeout counter (`$clog2(TIMEOUT_CYCLES+1)` bits) live in the top module.

## Test plan
- **Word read:** addr 0x1000, width 10, ack with `wb_dat_i` = 0xDEADBEEF at cycle 2 → `adr` = 0x400, `sel` = 1111, `we` = 0; OKAY with rdata 0xDEADBEEF at cycle 3.
- **Byte write:** addr 0x2003, wdata 0x000000A5 → `sel` = 1000, `dat_o` = 0xA5A5A5A5, `we` = 1; OKAY one cycle after ack.
- **Misaligned halfword:** addr 0x1001 → no `cyc`; ERROR at cycle 1; width 11 gives the same result.
- **Bus errors:** `wb_err_i` alone → ERROR; ack and err together → ERROR; rdata = 0 in both cases.
- **Timeout:** `TIMEOUT_CYCLES` = 4, slave silent → `stb` high for 4 cycles, then ERROR; `cyc` low afterwards.
- **Reset and back-to-back:**
  - `rst` pulsed in BUS → `cyc` drops immediately and no resp is produced.
  - A request held continuously across RESP → next ack exactly 3 cycles after the previous one.
